multdiv_controller: RTL and testbench

- Sequences the shared iterative multiplier/divider for the pipelined processor's execute (X) stage.
- On a mult/div instruction in X, it latches the operands, pulses the unit's start control for one cycle and stalls the pipeline until the unit reports ready (or a watchdog expires).
- It then presents one writeback beat: the result to rd, or an exception code to rstatus ($30).
- It also keeps a stall-cycle performance counter that the testbench can read.

---
 rtl/multdiv_ctrl_pkg.sv | 15 +
 rtl/md_watchdog.sv | 37 +++
 rtl/multdiv_controller.sv | 182 ++++++++++++++++++
 tb/tb_multdiv_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and default constants for the multiply/divide sequencer.
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } md_state_e;

  localparam int unsigned MULT_EXC_CODE_DEFAULT = 4;
  localparam int unsigned DIV_EXC_CODE_DEFAULT  = 5;
  localparam int unsigned RSTATUS_REG_DEFAULT   = 30;

endpackage

// File: rtl/md_watchdog.sv
// Clearable up-counter that flags the last permitted BUSY cycle of an operation.
module md_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count holds the number of BUSY cycles already elapsed, so this is the final one.
  assign expire_o = en_i && (count_q == TERMINAL);

endmodule

// File: rtl/multdiv_controller.sv
// Sequences the shared iterative mul/div unit for the X stage: start pulse,
// pipeline stall until ready or watchdog expiry, then a single writeback beat.
module multdiv_controller
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned RSTATUS_REG    = RSTATUS_REG_DEFAULT,
  parameter int unsigned MULT_EXC_CODE  = MULT_EXC_CODE_DEFAULT,
  parameter int unsigned DIV_EXC_CODE   = DIV_EXC_CODE_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      x_valid,
  input  logic                      x_is_mult,
  input  logic                      x_is_div,
  input  logic [REG_ADDR_WIDTH-1:0] x_rd,
  input  logic [DATA_WIDTH-1:0]     x_opA,
  input  logic [DATA_WIDTH-1:0]     x_opB,
  input  logic                      flush,
  output logic                      md_ctrl_mult,
  output logic                      md_ctrl_div,
  output logic [DATA_WIDTH-1:0]     md_opA,
  output logic [DATA_WIDTH-1:0]     md_opB,
  input  logic [DATA_WIDTH-1:0]     md_result,
  input  logic                      md_exception,
  input  logic                      md_ready,
  output logic                      stall,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      timeout_err,
  output logic [31:0]               busy_cycles
);

  localparam logic [REG_ADDR_WIDTH-1:0] RSTATUS_ADDR = REG_ADDR_WIDTH'(RSTATUS_REG);
  localparam logic [DATA_WIDTH-1:0]     MULT_CODE    = DATA_WIDTH'(MULT_EXC_CODE);
  localparam logic [DATA_WIDTH-1:0]     DIV_CODE     = DATA_WIDTH'(DIV_EXC_CODE);

  md_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      is_div_q, is_div_d, exc_q, exc_d;
  logic                      timeout_err_q, timeout_err_d;
  logic [31:0]               busy_cycles_q, busy_cycles_d;

  logic request, latch_en, capture_en, force_exc, wd_clear, wd_en, wd_expire;

  // Reset is folded in so stall is already low while reset is held.
  assign request = x_valid && (x_is_mult ^ x_is_div) && !reset;

  md_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear_i (wd_clear),
    .en_i    (wd_en),
    .expire_o(wd_expire)
  );

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    latch_en     = 1'b0;
    capture_en   = 1'b0;
    force_exc    = 1'b0;
    wd_clear     = 1'b0;
    wd_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (request && !flush) begin
          stall    = 1'b1;
          latch_en = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        stall        = 1'b1;
        md_ctrl_mult = !is_div_q;
        md_ctrl_div  = is_div_q;
        wd_clear     = 1'b1;
        state_d      = flush ? IDLE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        wd_en = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (md_ready) begin
          capture_en = 1'b1;
          state_d    = DONE;
        end else if (wd_expire) begin
          force_exc = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    opa_d         = opa_q;
    opb_d         = opb_q;
    rd_d          = rd_q;
    is_div_d      = is_div_q;
    result_d      = result_q;
    exc_d         = exc_q;
    timeout_err_d = timeout_err_q | force_exc;
    busy_cycles_d = busy_cycles_q + (stall ? 32'd1 : 32'd0);
    if (latch_en) begin
      opa_d    = x_opA;
      opb_d    = x_opB;
      rd_d     = x_rd;
      is_div_d = x_is_div;
    end
    if (capture_en) begin
      result_d = md_result;
      exc_d    = md_exception;
    end else if (force_exc) begin
      exc_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      timeout_err_q <= 1'b0;
      busy_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      timeout_err_q <= timeout_err_d;
      busy_cycles_q <= busy_cycles_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opa_q    <= '0;
      opb_q    <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  // Exceptions always report through rstatus, even when rd is $0.
  always_comb begin
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    if (state_q == DONE) begin
      if (exc_q) begin
        wb_valid = 1'b1;
        wb_rd    = RSTATUS_ADDR;
        wb_data  = is_div_q ? DIV_CODE : MULT_CODE;
      end else begin
        wb_valid = (rd_q != '0);
        wb_rd    = rd_q;
        wb_data  = result_q;
      end
    end
  end

  assign md_opA      = opa_q;
  assign md_opB      = opb_q;
  assign timeout_err = timeout_err_q;
  assign busy_cycles = busy_cycles_q;

endmodule

// File: tb/tb_multdiv_controller.sv
// Bench for multdiv_controller: acts as the mul/div unit and checks each
// operation against stall/writeback expectations computed from operand arithmetic.
module tb_multdiv_controller;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 40;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          x_valid = 1'b0, x_is_mult = 1'b0, x_is_div = 1'b0;
  logic [AW-1:0] x_rd = '0;
  logic [DW-1:0] x_opA = '0, x_opB = '0;
  logic          flush = 1'b0;
  logic          md_ctrl_mult, md_ctrl_div;
  logic [DW-1:0] md_opA, md_opB;
  logic [DW-1:0] md_result = '0;
  logic          md_exception = 1'b0, md_ready = 1'b0;
  logic          stall, wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          timeout_err;
  logic [31:0]   busy_cycles;

  int          checks = 0;
  int          failures = 0;
  int          gcyc = 0;
  int          done_g = 0;
  int          pulse_g = 0;
  logic [31:0] exp_busy = '0;
  logic        exp_to = 1'b0;

  multdiv_controller dut (
    .clock       (clock),
    .reset       (reset),
    .x_valid     (x_valid),
    .x_is_mult   (x_is_mult),
    .x_is_div    (x_is_div),
    .x_rd        (x_rd),
    .x_opA       (x_opA),
    .x_opB       (x_opB),
    .flush       (flush),
    .md_ctrl_mult(md_ctrl_mult),
    .md_ctrl_div (md_ctrl_div),
    .md_opA      (md_opA),
    .md_opB      (md_opB),
    .md_result   (md_result),
    .md_exception(md_exception),
    .md_ready    (md_ready),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .timeout_err (timeout_err),
    .busy_cycles (busy_cycles)
  );

  always #5 clock = ~clock;
  always @(posedge clock) gcyc <= gcyc + 1;

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stall"}, 64'(stall), 64'(0));
    chk({tag, "_mult"}, 64'(md_ctrl_mult), 64'(0));
    chk({tag, "_div"}, 64'(md_ctrl_div), 64'(0));
    chk({tag, "_opA"}, 64'(md_opA), 64'(0));
    chk({tag, "_opB"}, 64'(md_opB), 64'(0));
    chk({tag, "_wbv"}, 64'(wb_valid), 64'(0));
    chk({tag, "_wbrd"}, 64'(wb_rd), 64'(0));
    chk({tag, "_wbd"}, 64'(wb_data), 64'(0));
    chk({tag, "_terr"}, 64'(timeout_err), 64'(0));
    chk({tag, "_busy"}, 64'(busy_cycles), 64'(0));
  endtask

  // The emulated unit: unsigned product overflowing 32 bits, or a zero divisor, raise an exception.
  function automatic void unit_model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output bit exc);
    logic [63:0] p;
    if (is_div) begin
      exc = (b == 32'd0);
      res = exc ? 32'd0 : a / b;
    end else begin
      p   = 64'(a) * 64'(b);
      exc = (p[63:32] != 32'd0);
      res = p[31:0];
    end
  endfunction

  // mode: 0 unit answers after dly cycles, 1 unit stays silent, 2 flush on BUSY cycle evt
  // (0 = during START) then a stray ready, 3 reset on BUSY cycle evt.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int dly, input int mode, input int evt);
    logic [31:0] res;
    bit          exc, ended, exp_v;
    logic [4:0]  exp_rd;
    logic [31:0] exp_d;
    int          exp_stall, stall_n, pulses, pulse_c;
    unit_model(is_div, a, b, res, exc);
    if (mode == 1) exc = 1'b1;
    exp_stall = (mode == 0) ? dly + 2 : (mode == 1) ? TO + 2 : evt + 2;
    exp_v  = (mode >= 2) ? 1'b0 : (exc ? 1'b1 : (rd != 5'd0));
    exp_rd = exc ? 5'd30 : rd;
    exp_d  = exc ? (is_div ? 32'd5 : 32'd4) : res;

    @(negedge clock);
    x_valid = 1'b1; x_is_mult = !is_div; x_is_div = is_div;
    x_rd = rd; x_opA = a; x_opB = b; md_ready = 1'b0; flush = 1'b0;
    #2;
    chk("req_stall", 64'(stall), 64'(1));
    stall_n = 1; pulses = 0; pulse_c = -1; ended = 1'b0;
    for (int c = 1; c <= TO + 10 && !ended; c++) begin
      @(negedge clock);
      md_ready = 1'b0; md_exception = 1'b0; md_result = $urandom; flush = 1'b0;
      if (c == 1 && mode != 1) begin
        md_ready = 1'b1;
        md_exception = 1'($urandom);
      end
      if (mode == 0 && c == 1 + dly) begin
        md_ready = 1'b1; md_result = res; md_exception = exc;
      end
      if (mode == 2 && c == 1 + evt) flush = 1'b1;
      if (mode == 2 && c == 2 + evt) begin
        x_valid = 1'b0;
        md_ready = 1'b1;
      end
      if (mode == 3 && c == 1 + evt) begin
        #1 reset = 1'b1;
        #1;
        check_zero("async_rst");
        x_valid = 1'b0;
        #1 reset = 1'b0;
        exp_busy = '0;
        exp_to = 1'b0;
        return;
      end
      #2;
      if (md_ctrl_mult || md_ctrl_div) begin
        pulses++;
        pulse_c = c;
        pulse_g = gcyc;
        chk("pulse_is_div", 64'(md_ctrl_div), 64'(is_div));
        chk("pulse_opA", 64'(md_opA), 64'(a));
        chk("pulse_opB", 64'(md_opB), 64'(b));
      end
      if (stall) begin
        stall_n++;
        chk("wb_in_stall", 64'(wb_valid), 64'(0));
      end else begin
        ended = 1'b1;
      end
    end
    chk("op_ended", 64'(ended), 64'(1));
    chk("stall_cycles", 64'(stall_n), 64'(exp_stall));
    chk("start_pulses", 64'(pulses), 64'(1));
    chk("pulse_cycle", 64'(pulse_c), 64'(1));
    chk("wb_valid", 64'(wb_valid), 64'(exp_v));
    if (exp_v) begin
      chk("wb_rd", 64'(wb_rd), 64'(exp_rd));
      chk("wb_data", 64'(wb_data), 64'(exp_d));
    end
    chk("opA_hold", 64'(md_opA), 64'(a));
    chk("opB_hold", 64'(md_opB), 64'(b));
    exp_busy = exp_busy + 32'(exp_stall);
    if (mode == 1) exp_to = 1'b1;
    chk("busy_cycles", 64'(busy_cycles), 64'(exp_busy));
    chk("timeout_err", 64'(timeout_err), 64'(exp_to));
    done_g = gcyc;
  endtask

  task automatic idle_cycle(input logic vld, input logic m, input logic d, input logic fl,
                            input string tag);
    @(negedge clock);
    x_valid = vld; x_is_mult = m; x_is_div = d; flush = fl;
    md_ready = 1'($urandom); md_result = $urandom; md_exception = 1'($urandom);
    #2;
    chk({tag, "_stall"}, 64'(stall), 64'(0));
    chk({tag, "_wb"}, 64'(wb_valid), 64'(0));
    @(negedge clock);
    x_valid = 1'b0; flush = 1'b0; md_ready = 1'b0;
    #2;
    chk({tag, "_nostart"}, 64'({md_ctrl_mult, md_ctrl_div}), 64'(0));
    chk({tag, "_stall2"}, 64'(stall), 64'(0));
    chk({tag, "_busy"}, 64'(busy_cycles), 64'(exp_busy));
  endtask

  initial begin
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          mode, dly, evt, prev_done;
    bit          dv;

    repeat (2) @(negedge clock);
    #2;
    check_zero("reset");
    reset = 1'b0;

    run_op(1'b0, 32'd7, 32'd6, 5'd3, 17, 0, 0);
    chk("plan_busy19", 64'(busy_cycles), 64'(19));
    run_op(1'b1, 32'd100, 32'd0, 5'd5, 4, 0, 0);
    idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, "gap1");
    run_op(1'b0, 32'd5, 32'd9, 5'd0, 3, 0, 0);
    idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, "resume");
    run_op(1'b1, 32'd77, 32'd7, 5'd8, 1, 1, 0);
    idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, "gap2");
    run_op(1'b0, 32'd3, 32'd4, 5'd9, 10, 2, 3);
    run_op(1'b0, 32'd11, 32'd12, 5'd10, 2, 0, 0);

    run_op(1'b0, 32'd1000, 32'd3, 5'd11, 5, 0, 0);
    prev_done = done_g;
    run_op(1'b1, 32'd1000, 32'd3, 5'd12, 6, 0, 0);
    chk("b2b_gap", 64'(pulse_g - prev_done), 64'(2));

    idle_cycle(1'b1, 1'b1, 1'b1, 1'b0, "both_set");
    idle_cycle(1'b1, 1'b0, 1'b0, 1'b0, "neither");
    idle_cycle(1'b1, 1'b1, 1'b0, 1'b1, "flush_idle");

    for (int i = 0; i < 25; i++) begin
      dv   = 1'($urandom);
      a    = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 50000);
      b    = ($urandom_range(0, 5) == 0) ? 32'd0 :
             (($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 50000));
      rd   = 5'($urandom);
      dly  = int'($urandom_range(1, 20));
      mode = ($urandom_range(0, 4) == 0) ? 2 : 0;
      evt  = int'($urandom_range(0, 5));
      run_op(dv, a, b, rd, dly, mode, evt);
      if ($urandom_range(0, 1) == 1) idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, "rand_gap");
    end

    run_op(1'b1, 32'd9, 32'd9, 5'd4, 1, 1, 0);
    run_op(1'b0, 32'd123, 32'd456, 5'd7, 30, 3, 5);
    run_op(1'b0, 32'd123, 32'd456, 5'd7, 4, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
